// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART receiver and its optional hex decoder.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam logic [7:0] AsciiZero    = 8'h30;
    localparam logic [7:0] AsciiNine    = 8'h39;
    localparam logic [7:0] AsciiLowerA  = 8'h61;
    localparam logic [7:0] AsciiLowerF  = 8'h66;
    localparam logic [7:0] AsciiUpperA  = 8'h41;
    localparam logic [7:0] AsciiUpperF  = 8'h46;
    localparam logic [7:0] AsciiNewline = 8'h0A;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= AsciiZero) && (c <= AsciiNine)) ||
               ((c >= AsciiLowerA) && (c <= AsciiLowerF)) ||
               ((c >= AsciiUpperA) && (c <= AsciiUpperF));
    endfunction

    function automatic logic [3:0] hex_nibble(input logic [7:0] c);
        logic [7:0] v;
        if (c <= AsciiNine) begin
            v = c - AsciiZero;
        end else if (c >= AsciiLowerA) begin
            v = c - AsciiLowerA + 8'd10;
        end else begin
            v = c - AsciiUpperA + 8'd10;
        end
        return v[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_hexdec.sv
// ASCII hex pair decoder behind the UART receiver; compiled only with UART_RX_HEX_EN.
// Non-hex characters and framing errors drop any pending high nibble.
`ifdef UART_RX_HEX_EN
module uart_rx_hexdec
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    input  logic       char_err,
    output logic [7:0] byte_data,
    output logic       byte_valid
);

    logic       pending_q, pending_d;
    logic [3:0] hi_q, hi_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    always_comb begin
        pending_d = pending_q;
        hi_d      = hi_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        if (char_err) begin
            pending_d = 1'b0;
        end else if (char_valid) begin
            if (!is_hex(char_data)) begin
                pending_d = 1'b0;
            end else if (pending_q) begin
                data_d    = {hi_q, hex_nibble(char_data)};
                valid_d   = 1'b1;
                pending_d = 1'b0;
            end else begin
                hi_d      = hex_nibble(char_data);
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            hi_q      <= 4'h0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            hi_q      <= hi_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;

endmodule
`endif

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and break handling.
// Define UART_RX_HEX_EN to decode received ASCII hex pairs into bytes instead of raw output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_ferr
);

    localparam logic [15:0] BitLast  = 16'(UART_CLK_DIV - 1);
    localparam logic [15:0] HalfLast = 16'(UART_CLK_DIV / 2 - 1);

    logic       sync_q, rx_s;
    logic [1:0] prime_q;
    logic       armed_q, armed_d;
    rx_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_ok, frame_err;
    logic       ferr_q;

    // prime_q[1] marks rx_s as carrying a real line sample rather than the reset value;
    // armed_q requires the line to have been seen high before any start edge counts.
    assign armed_d = armed_q | (prime_q[1] & rx_s);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (prime_q[1] && !rx_s) begin
                    state_d = armed_q ? StStart : StBreak;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = 16'd0;
                    byte_ok   = rx_s;
                    frame_err = !rx_s;
                    state_d   = rx_s ? StIdle : StBreak;
                end
            end
            StBreak: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            rx_s    <= 1'b1;
            prime_q <= 2'b00;
            armed_q <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= i_uart_rx;
            rx_s    <= sync_q;
            prime_q <= {prime_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= frame_err;
        end
    end

    assign o_ferr = ferr_q;

`ifdef UART_RX_HEX_EN
    uart_rx_hexdec u_hexdec (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_data  (shift_q),
        .char_valid (byte_ok),
        .char_err   (frame_err),
        .byte_data  (o_data),
        .byte_valid (o_valid)
    );
`else
    logic       valid_q;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= byte_ok;
            if (byte_ok) begin
                data_q <= shift_q;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 115200 baud, one at divide-by-16.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       valid_a, ferr_a, valid_b, ferr_b;
    logic [7:0] data_a, data_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int nferr_a = 0;
    int nferr_b = 0;
    int n_both  = 0;

    uart_rx #(.UART_CLK_DIV(868)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (rx_a),
        .o_valid   (valid_a),
        .o_data    (data_a),
        .o_ferr    (ferr_a)
    );

    uart_rx #(.UART_CLK_DIV(16)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (rx_b),
        .o_valid   (valid_b),
        .o_data    (data_b),
        .o_ferr    (ferr_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_a) q_a.push_back(data_a);
        if (valid_b) q_b.push_back(data_b);
        if (ferr_a) nferr_a++;
        if (ferr_b) nferr_b++;
        if ((valid_a && ferr_a) || (valid_b && ferr_b)) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rx_at(input bit sel, input int i);
        if (sel) return (i < q_b.size()) ? q_b[i] : 8'hxx;
        return (i < q_a.size()) ? q_a[i] : 8'hxx;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
        wait_cycles(sel ? 16 : 868);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
        drive_bit(sel, stop);
        if (sel) rx_b = 1'b1;
        else rx_a = 1'b1;
    endtask

    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send_frame(sel, s[i], 1'b1);
    endtask

    initial begin
        int base, fbase;
        wait_cycles(5);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_data_a", 32'(data_a), 32'h00);
        check("rst_ferr_a", 32'(ferr_a), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        check("rst_data_b", 32'(data_b), 32'h00);
        check("rst_ferr_b", 32'(ferr_b), 32'd0);
        rst_n = 1'b1;
        wait_cycles(10);

`ifdef UART_RX_HEX_EN
        base = q_b.size();
        send_str(1'b1, "3A\n");
        wait_cycles(10);
        check("hex_3a_count", 32'(q_b.size() - base), 32'd1);
        check("hex_3a_data", 32'(rx_at(1'b1, base)), 32'h3A);

        base = q_b.size();
        send_str(1'b1, "a5 7\nFf");
        wait_cycles(10);
        check("hex_a5ff_count", 32'(q_b.size() - base), 32'd2);
        check("hex_a5_data", 32'(rx_at(1'b1, base)), 32'hA5);
        check("hex_ff_data", 32'(rx_at(1'b1, base + 1)), 32'hFF);

        // A framing error between nibbles must drop the pending '1'.
        base  = q_b.size();
        fbase = nferr_b;
        send_str(1'b1, "1");
        send_frame(1'b1, 8'h39, 1'b0);
        wait_cycles(20);
        send_str(1'b1, "45");
        wait_cycles(10);
        check("hex_ferr_pulse", 32'(nferr_b - fbase), 32'd1);
        check("hex_ferr_count", 32'(q_b.size() - base), 32'd1);
        check("hex_ferr_data", 32'(rx_at(1'b1, base)), 32'h45);
        check("hex_data_held", 32'(data_b), 32'h45);
`else
        base  = q_a.size();
        fbase = nferr_a;
        send_frame(1'b0, 8'h55, 1'b1);
        wait_cycles(20);
        check("raw55_count", 32'(q_a.size() - base), 32'd1);
        check("raw55_data", 32'(rx_at(1'b0, base)), 32'h55);
        check("raw55_ferr", 32'(nferr_a - fbase), 32'd0);
        check("raw55_held", 32'(data_a), 32'h55);

        base = q_a.size();
        rx_a = 1'b0;
        wait_cycles(200);
        rx_a = 1'b1;
        wait_cycles(1000);
        check("glitch_valid", 32'(q_a.size() - base), 32'd0);
        check("glitch_ferr", 32'(nferr_a - fbase), 32'd0);
        check("glitch_state", 32'(u_dut_a.state_q), 32'(StIdle));

        send_frame(1'b0, 8'hA3, 1'b0);
        wait_cycles(50);
        check("ferr_pulse", 32'(nferr_a - fbase), 32'd1);
        check("ferr_no_valid", 32'(q_a.size() - base), 32'd0);
        send_frame(1'b0, 8'h0F, 1'b1);
        wait_cycles(20);
        check("after_ferr_count", 32'(q_a.size() - base), 32'd1);
        check("after_ferr_data", 32'(rx_at(1'b0, base)), 32'h0F);

        base = q_b.size();
        send_frame(1'b1, 8'h00, 1'b1);
        send_frame(1'b1, 8'hFF, 1'b1);
        send_frame(1'b1, 8'h81, 1'b1);
        wait_cycles(20);
        check("b2b_count", 32'(q_b.size() - base), 32'd3);
        check("b2b_0", 32'(rx_at(1'b1, base)), 32'h00);
        check("b2b_1", 32'(rx_at(1'b1, base + 1)), 32'hFF);
        check("b2b_2", 32'(rx_at(1'b1, base + 2)), 32'h81);

        // Reset lands in data bit 2 of an 0xFF frame; the remaining bits idle high.
        base  = q_a.size();
        fbase = nferr_a;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        wait_cycles(400);
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(466);
        for (int i = 0; i < 6; i++) drive_bit(1'b0, 1'b1);
        wait_cycles(20);
        check("rst_frame_dropped", 32'(q_a.size() - base), 32'd0);
        send_frame(1'b0, 8'h42, 1'b1);
        wait_cycles(20);
        check("rst_next_count", 32'(q_a.size() - base), 32'd1);
        check("rst_next_data", 32'(rx_at(1'b0, base)), 32'h42);
        check("rst_next_ferr", 32'(nferr_a - fbase), 32'd0);

        // Line held low across reset must not be taken as a start bit.
        base  = q_b.size();
        fbase = nferr_b;
        rx_b  = 1'b0;
        wait_cycles(10);
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(100);
        rx_b = 1'b1;
        wait_cycles(20);
        check("held_low_quiet", 32'(q_b.size() - base), 32'd0);
        send_frame(1'b1, 8'h5A, 1'b1);
        wait_cycles(20);
        check("held_low_ferr", 32'(nferr_b - fbase), 32'd0);
        check("held_low_count", 32'(q_b.size() - base), 32'd1);
        check("held_low_data", 32'(rx_at(1'b1, base)), 32'h5A);
`endif

        check("never_both", 32'(n_both), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
